// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the ID-stage hazard detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_unit_pkg;

  // Architectural register-select width (eight registers, R0 is ordinary).
  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] reg_sel_t;

  // Link register written by JAL/JALR.
  localparam reg_sel_t REG_LINK = reg_sel_t'(7);

  // Pipeline positions tracked by the in-flight writer scoreboard.
  typedef enum logic [1:0] {
    SB_EX  = 2'd0,
    SB_MEM = 2'd1,
    SB_WB  = 2'd2
  } sb_stage_e;

  // One scoreboard slot: valid, destination, writes-RF, is-load.
  typedef struct packed {
    logic     v;
    reg_sel_t dest;
    logic     wr;
    logic     ld;
  } sb_entry_t;

  // Empty slot, used for bubbles, flushes and reset.
  localparam sb_entry_t SB_NOP = '{v: 1'b0, dest: '0, wr: 1'b0, ld: 1'b0};

  // Build an occupied slot from the decode-stage write controls.
  function automatic sb_entry_t sb_make(input reg_sel_t dest, input logic wr, input logic ld);
    sb_entry_t e;
    e.v    = 1'b1;
    e.dest = dest;
    e.wr   = wr;
    e.ld   = ld;
    return e;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode-stage hazard interface: ID instruction fields in, stall/bubble/count out.
// Latency: n/a (wiring only); outputs are combinational on the ID fields.
// Backpressure: mem_stall freezes the consumer; stall_ID holds the producer.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  import hazard_stall_unit_pkg::*;

  logic             valid_ID;
  reg_sel_t         read1RegSel_ID;
  reg_sel_t         read2RegSel_ID;
  logic             uses1_ID;
  logic             uses2_ID;
  reg_sel_t         Write_register_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic             flush;
  logic             mem_stall;
  logic             stall_ID;
  logic             bubble_EX;
  logic [CNT_W-1:0] stall_count;

  // Pipeline control side: presents the decoding instruction.
  modport master (
    output valid_ID, read1RegSel_ID, read2RegSel_ID, uses1_ID, uses2_ID,
    output Write_register_ID, RegWrite_ID, MemRead_ID, flush, mem_stall,
    input  stall_ID, bubble_EX, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  valid_ID, read1RegSel_ID, read2RegSel_ID, uses1_ID, uses2_ID,
    input  Write_register_ID, RegWrite_ID, MemRead_ID, flush, mem_stall,
    output stall_ID, bubble_EX, stall_count
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One registered scoreboard slot with hold, clear and load controls.
// Latency: 1 cycle from d to q.
// Backpressure: hold has priority over clear and load and freezes the slot.
module hazard_sb_entry
  import hazard_stall_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      clear,
  input  logic      load,
  input  sb_entry_t d,
  output sb_entry_t q
);

  // Reset empties the slot; a frozen pipe keeps it; otherwise bubble or capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SB_NOP;
    end else if (!hold) begin
      if (clear) begin
        q <= SB_NOP;
      end else if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: scoreboard of EX/MEM/WB writers, stall + bubble, stall counter.
// Latency: stall_ID/bubble_EX combinational on ID fields; scoreboard and counter update each clk.
// Backpressure: mem_stall freezes scoreboard and counter; stall_ID holds PC and IF/ID.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_unit_if.slave hz
);

  sb_entry_t        sb_ex;
  sb_entry_t        sb_mem;
  sb_entry_t        sb_wb;
  sb_entry_t        ex_next;
  logic             hit_ex;
  logic             hit_mem;
  logic             hit_wb;
  logic             hazard;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  // A slot hits when it will write a register that the ID instruction actually reads.
  function automatic logic src_hit(
    input sb_entry_t e,
    input reg_sel_t  r1,
    input reg_sel_t  r2,
    input logic      u1,
    input logic      u2
  );
    return e.v & e.wr & ((u1 & (r1 == e.dest)) | (u2 & (r2 == e.dest)));
  endfunction

  // Compare both sources against every in-flight writer.
  always_comb begin
    hit_ex  = src_hit(sb_ex,  hz.read1RegSel_ID, hz.read2RegSel_ID, hz.uses1_ID, hz.uses2_ID);
    hit_mem = src_hit(sb_mem, hz.read1RegSel_ID, hz.read2RegSel_ID, hz.uses1_ID, hz.uses2_ID);
    hit_wb  = src_hit(sb_wb,  hz.read1RegSel_ID, hz.read2RegSel_ID, hz.uses1_ID, hz.uses2_ID);
  end

  // With forwarding only a load still in EX is uncoverable; without it any
  // in-flight match stalls, except WB when the register file bypasses it.
  always_comb begin
    if (FWD_EN) begin
      hazard = hit_ex & sb_ex.ld;
    end else begin
      hazard = hit_ex | hit_mem | (hit_wb & ~RF_BYPASS);
    end
  end

  // Flush beats a hazard; reset suppresses the stall so a frozen PC cannot
  // survive into the first post-reset cycle.
  always_comb begin
    stall   = hz.valid_ID & hazard & ~hz.flush & rst_n;
    bubble  = stall | hz.flush | ~hz.valid_ID;
    ex_next = sb_make(hz.Write_register_ID, hz.RegWrite_ID, hz.MemRead_ID);
  end

  assign hz.stall_ID    = stall;
  assign hz.bubble_EX   = bubble;
  assign hz.stall_count = stall_cnt;

  // EX slot takes the decoding instruction, or a bubble when it is held or killed.
  hazard_sb_entry u_sb_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hz.mem_stall),
    .clear (bubble),
    .load  (1'b1),
    .d     (ex_next),
    .q     (sb_ex)
  );

  // MEM slot follows EX.
  hazard_sb_entry u_sb_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hz.mem_stall),
    .clear (1'b0),
    .load  (1'b1),
    .d     (sb_ex),
    .q     (sb_mem)
  );

  // WB slot follows MEM.
  hazard_sb_entry u_sb_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hz.mem_stall),
    .clear (1'b0),
    .load  (1'b1),
    .d     (sb_mem),
    .q     (sb_wb)
  );

  // Count hazard stall cycles that actually advance the pipe, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!hz.mem_stall && stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: three configurations driven by one shared stimulus.
// Latency: checks combinational outputs mid-cycle, state after each edge.
// Backpressure: mem_stall exercised in a dedicated sequence.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  typedef struct packed {
    logic     valid;
    reg_sel_t r1;
    reg_sel_t r2;
    logic     u1;
    logic     u2;
    reg_sel_t wd;
    logic     rw;
    logic     mr;
    logic     fl;
    logic     ms;
  } stim_t;

  typedef struct {
    logic  rst_n;
    stim_t in;
    logic  exp_stall;
    logic  exp_bubble;
    int    exp_cnt;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  stim_t stim;
  int    checks = 0;
  int    errors = 0;
  vec_t  vq[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(4))  if_fwd ();
  hazard_stall_unit_if #(.CNT_W(16)) if_nf ();
  hazard_stall_unit_if #(.CNT_W(16)) if_nb ();

  assign {if_fwd.valid_ID, if_fwd.read1RegSel_ID, if_fwd.read2RegSel_ID, if_fwd.uses1_ID,
          if_fwd.uses2_ID, if_fwd.Write_register_ID, if_fwd.RegWrite_ID, if_fwd.MemRead_ID,
          if_fwd.flush, if_fwd.mem_stall} = stim;
  assign {if_nf.valid_ID, if_nf.read1RegSel_ID, if_nf.read2RegSel_ID, if_nf.uses1_ID,
          if_nf.uses2_ID, if_nf.Write_register_ID, if_nf.RegWrite_ID, if_nf.MemRead_ID,
          if_nf.flush, if_nf.mem_stall} = stim;
  assign {if_nb.valid_ID, if_nb.read1RegSel_ID, if_nb.read2RegSel_ID, if_nb.uses1_ID,
          if_nb.uses2_ID, if_nb.Write_register_ID, if_nb.RegWrite_ID, if_nb.MemRead_ID,
          if_nb.flush, if_nb.mem_stall} = stim;

  hazard_stall_unit #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(4)) u_fwd (
    .clk(clk), .rst_n(rst_n), .hz(if_fwd.slave));
  hazard_stall_unit #(.FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(16)) u_nf (
    .clk(clk), .rst_n(rst_n), .hz(if_nf.slave));
  hazard_stall_unit #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(16)) u_nb (
    .clk(clk), .rst_n(rst_n), .hz(if_nb.slave));

  function automatic stim_t ins(input logic v, input int r1, input int r2, input logic u1,
                                input logic u2, input int wd, input logic rw, input logic mr,
                                input logic fl, input logic ms);
    stim_t s;
    s.valid = v;  s.r1 = reg_sel_t'(r1); s.r2 = reg_sel_t'(r2);
    s.u1 = u1;    s.u2 = u2;             s.wd = reg_sel_t'(wd);
    s.rw = rw;    s.mr = mr;             s.fl = fl;  s.ms = ms;
    return s;
  endfunction

  task automatic add(input logic r, input stim_t s, input logic es, input logic eb, input int ec);
    vec_t v;
    v.rst_n = r; v.in = s; v.exp_stall = es; v.exp_bubble = eb; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stim  = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    stim_t idle, ld_r1, add_r1, sub_dep, add_dep;
    idle    = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ld_r1   = ins(1, 6, 0, 1, 0, 1, 1, 1, 0, 0);   // LD R1,[R6]
    add_dep = ins(1, 1, 3, 1, 1, 2, 1, 0, 0, 0);   // ADD R2,R1,R3
    add_r1  = ins(1, 4, 5, 1, 1, 1, 1, 0, 0, 0);   // ADD R1,R4,R5
    sub_dep = ins(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);   // SUB R2,R1,R1

    // Forwarding configuration: {rst_n, instruction, stall, bubble, count-at-cycle-start}
    add(0, idle,                                   0, 1, 0);
    add(1, ld_r1,                                  0, 0, 0);
    add(1, add_dep,                                1, 1, 0);
    add(1, add_dep,                                0, 0, 1);
    add(1, ins(1, 2, 0, 1, 0, 3, 1, 1, 0, 0),      0, 0, 1);  // LD R3,[R2] after ALU R2
    add(1, ins(1, 5, 6, 1, 1, 4, 1, 0, 0, 0),      0, 0, 1);  // independent of LD R3
    add(1, ins(1, 7, 0, 1, 0, 0, 1, 1, 0, 0),      0, 0, 1);  // LD R0,[R7]
    add(1, ins(1, 0, 0, 1, 1, 1, 1, 0, 0, 0),      1, 1, 1);  // both sources R0
    add(1, ins(1, 0, 0, 1, 1, 1, 1, 0, 0, 0),      0, 0, 2);
    add(1, ins(1, 0, 0, 0, 0, REG_LINK, 1, 0, 0, 0), 0, 0, 2); // JAL writes R7
    add(1, ins(1, 7, 0, 1, 0, 5, 1, 1, 0, 0),      0, 0, 2);  // LD R5,[R7]
    add(1, ins(1, 5, 5, 0, 0, 0, 0, 0, 0, 0),      0, 0, 2);  // HALT with matching fields
    add(1, ins(0, 5, 0, 1, 0, 0, 0, 0, 0, 0),      0, 1, 2);  // empty slot
    add(1, ins(1, 1, 0, 1, 0, 5, 1, 1, 0, 0),      0, 0, 2);  // LD R5,[R1]
    add(1, ins(1, 5, 0, 1, 0, 2, 1, 0, 1, 0),      0, 1, 2);  // dependent + flush
    add(1, ins(1, 5, 0, 1, 0, 2, 1, 0, 0, 0),      0, 0, 2);
    add(1, ins(1, 1, 0, 1, 0, 3, 1, 1, 0, 0),      0, 0, 2);  // LD R3,[R1]
    add(1, ins(1, 4, 3, 1, 1, 6, 1, 0, 0, 0),      1, 1, 2);  // only src2 matches
    add(1, ins(1, 4, 3, 1, 1, 6, 1, 0, 0, 0),      0, 0, 3);
    add(1, ins(1, 0, 0, 1, 0, 4, 1, 1, 0, 0),      0, 0, 3);  // LD R4,[R0]
    add(1, ins(1, 4, 2, 0, 1, 7, 1, 0, 0, 0),      0, 0, 3);  // R4 field present but unused

    rst_n = 1'b0;
    stim  = idle;
    repeat (2) @(posedge clk);
    #1;

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      stim  = vq[i].in;
      settle();
      check($sformatf("vec%0d stall", i),  32'(if_fwd.stall_ID),    32'(vq[i].exp_stall));
      check($sformatf("vec%0d bubble", i), 32'(if_fwd.bubble_EX),   32'(vq[i].exp_bubble));
      check($sformatf("vec%0d count", i),  32'(if_fwd.stall_count), 32'(vq[i].exp_cnt));
      tick();
    end

    // No forwarding: RAW on an ALU result stalls 2 cycles with RF bypass, 3 without.
    begin
      logic exp_nf [4];
      logic exp_nb [4];
      exp_nf = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_nb = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      stim = add_r1;
      settle();
      check("nofwd producer stall", 32'(if_nf.stall_ID), 32'(0));
      tick();
      for (int c = 0; c < 4; c++) begin
        stim = sub_dep;
        settle();
        check($sformatf("nofwd byp c%0d stall", c),   32'(if_nf.stall_ID), 32'(exp_nf[c]));
        check($sformatf("nofwd nobyp c%0d stall", c), 32'(if_nb.stall_ID), 32'(exp_nb[c]));
        if (c == 0) begin
          check("nofwd bubble", 32'(if_nf.bubble_EX), 32'(1));
          check("fwd alu-use stall", 32'(if_fwd.stall_ID), 32'(0));
        end
        tick();
      end
      check("nofwd byp count",   32'(if_nf.stall_count), 32'(2));
      check("nofwd nobyp count", 32'(if_nb.stall_count), 32'(3));
    end

    // Load-use while the memory freezes the pipe for three cycles.
    do_reset();
    stim = ld_r1;
    tick();
    for (int c = 0; c < 3; c++) begin
      stim = add_dep;
      stim.ms = 1'b1;
      settle();
      check($sformatf("memstall c%0d stall", c), 32'(if_fwd.stall_ID),    32'(1));
      check($sformatf("memstall c%0d count", c), 32'(if_fwd.stall_count), 32'(0));
      tick();
    end
    stim = add_dep;
    settle();
    check("memstall unfrozen stall", 32'(if_fwd.stall_ID), 32'(1));
    tick();
    settle();
    check("memstall release stall", 32'(if_fwd.stall_ID),    32'(0));
    check("memstall final count",   32'(if_fwd.stall_count), 32'(1));
    tick();

    // Flush coinciding with a load-use hazard kills the ID instruction.
    do_reset();
    stim = ld_r1;
    tick();
    stim = add_dep;
    stim.fl = 1'b1;
    settle();
    check("flush stall",  32'(if_fwd.stall_ID),  32'(0));
    check("flush bubble", 32'(if_fwd.bubble_EX), 32'(1));
    tick();
    check("flush ex valid", 32'(u_fwd.sb_ex.v), 32'(0));
    stim = ins(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);     // reads only the flushed dest R2
    settle();
    check("flush nofwd no stale writer", 32'(if_nf.stall_ID), 32'(0));
    tick();

    // Reset asserted in the middle of a stall.
    do_reset();
    stim = ld_r1;
    tick();
    stim = add_dep;
    settle();
    check("rst mid stall before", 32'(if_fwd.stall_ID), 32'(1));
    tick();
    rst_n = 1'b0;
    settle();
    check("rst mid stall during", 32'(if_fwd.stall_ID), 32'(0));
    tick();
    rst_n = 1'b1;
    settle();
    check("rst mid stall after",  32'(if_fwd.stall_ID),    32'(0));
    check("rst mid stall count",  32'(if_fwd.stall_count), 32'(0));
    tick();

    // Twenty load-use stalls on a 4-bit counter must saturate at 15.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      stim = ld_r1;
      tick();
      stim = add_dep;
      settle();
      check($sformatf("sat iter%0d stall", k), 32'(if_fwd.stall_ID), 32'(1));
      tick();
      settle();
      if (k == 14) check("sat count at 15 stalls", 32'(if_fwd.stall_count), 32'(15));
      tick();
    end
    check("sat final count", 32'(if_fwd.stall_count), 32'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decode-stage (ID) hazard detector; the producer-side counterpart of the EX-stage forwarding network.
- Keeps a 3-entry in-flight writer scoreboard (EX, MEM, WB) and compares each decoding instruction's source registers against it.
- Asserts a stall and inserts a bubble whenever forwarding cannot cover the dependence.
- Also counts stall cycles for performance reporting.

Parameters:
- FWD_EN, 1: 1 = EX-EX and MEM-EX forwarding present, so only load-use stalls are needed; 0 = no forwarding, so stall on any in-flight match.
- RF_BYPASS, 1: 1 = the register file forwards a same-cycle WB write to an ID read, so the WB entry never causes a stall.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low (decided: single clock, synchronous active-low reset)
- valid_ID  in  1  ID holds a real instruction
- read1RegSel_ID  in  3  source register 1
- read2RegSel_ID  in  3  source register 2
- uses1_ID  in  1  instruction reads source 1
- uses2_ID  in  1  instruction reads source 2
- Write_register_ID  in  3  destination register (R7 for JAL/JALR link)
- RegWrite_ID  in  1  instruction writes the register file
- MemRead_ID  in  1  instruction is a load
- flush  in  1  branch/jump mispredict resolved this cycle; kill ID
- mem_stall  in  1  memory not ready; whole pipeline frozen
- stall_ID  out  1  hold PC and the IF/ID register
- bubble_EX  out  1  load a NOP into ID/EX
- stall_count  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
Scoreboard state:
- Entries EX, MEM and WB. Each holds {v, dest[2:0], wr, ld}.
- R0 is an ordinary register; no zero-register exemption applies.

Hit detection (combinational):
- hit(e) = e.v & e.wr & ((uses1_ID & read1RegSel_ID==e.dest) | (uses2_ID & read2RegSel_ID==e.dest)).
- FWD_EN=1: hazard = hit(EX) & EX.ld.
- FWD_EN=0: hazard = hit(EX) | hit(MEM) | (hit(WB) & ~RF_BYPASS).

Outputs (combinational):
- stall_ID = valid_ID & hazard & ~flush & rst_n.
- bubble_EX = stall_ID | flush | ~valid_ID.

Shift rule (per clk):
- rst_n=0: every entry v=0 and stall_count=0. No stall is asserted on or after reset until a writer enters the scoreboard.
- mem_stall=1: all entries and the counter hold. mem_stall takes priority over flush and hazard; the pipeline controller re-presents flush once the pipe is unfrozen.
- Otherwise: WB<=MEM and MEM<=EX.
  - bubble_EX=1: EX<={v=0}.
  - bubble_EX=0: EX<={1, Write_register_ID, RegWrite_ID, MemRead_ID}.
- stall_count increments on each non-frozen cycle with stall_ID=1 and saturates at all-ones.

Latency:
- Load-use with FWD_EN=1: exactly 1 stall cycle. On the next cycle the load sits in MEM and the MEM-EX path covers it.
- FWD_EN=0, RF_BYPASS=1: at most 2 stall cycles.
- FWD_EN=0, RF_BYPASS=0: at most 3 stall cycles.

Boundary cases:
- flush together with a hazard: flush wins, so stall_ID=0 and a bubble is inserted.
- A load whose dest matches both sources causes a single stall, not a double one.
- A NOP/HALT with uses1/2=0 never stalls.
- A stalled instruction re-evaluates every cycle and releases as soon as the entry advances.
- Reset mid-stall: the next cycle has stall_ID=0 and an empty scoreboard.

Decomposition:
- Shared package holds:
  - REG_W=3
  - the scoreboard-entry typedef {v, dest, wr, ld}
  - the NOP entry constant
  - the R7 link-register constant
- One natural sub-module, hazard_sb_entry: a registered entry with hold/load/clear and rst_n, instantiated three times.
- Hit comparison and the counter stay in the top module.

Test Plan:
- FWD_EN=1: LD R1 in EX, ADD R2,R1,R3 in ID -> stall_ID=1 and bubble_EX=1 for one cycle; next cycle stall_ID=0; stall_count=1.
- FWD_EN=1: LD R1 in EX, ADD R2,R4,R5 in ID -> stall_ID=0; ADD enters EX the next cycle.
- FWD_EN=0, RF_BYPASS=1: ADD R1 in EX, SUB R2,R1,R1 in ID -> stall_ID high for 2 cycles, then release; stall_count=2.
- Load-use hazard with flush=1 in the same cycle -> stall_ID=0, bubble_EX=1, EX entry v=0.
- Load-use hazard with mem_stall=1 for 3 cycles -> stall_ID stays 1 and the scoreboard holds; after mem_stall drops, 1 more stall cycle follows, then release; stall_count=1.
- CNT_W=4 with 20 load-use stalls -> stall_count=15.
- Assert rst_n=0 during a stall -> next cycle stall_ID=0 and stall_count=0.
